// File: rtl/lsu_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_dmem_ctrl
//   Load/store unit between the execute stage and a synchronous data memory.
//   Checks alignment, steers store bytes onto lanes and generates write
//   strobes, and sign/zero-extends load data. A small FSM with a latency
//   counter sequences the memory read latency.
//
//   Handshake: a request is accepted in the cycle where req_valid and
//   req_ready are both high. The memory access is issued combinationally in
//   that same cycle. The response is a single-cycle resp_valid pulse with no
//   backpressure. req_ready stays low until that pulse has been delivered.
//
//   Op encoding (req_op): 0 LB, 1 LH, 2 LW, 3 LBU, 4 LHU, 5 SB, 6 SH, 7 SW.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake from the execute stage
//   req_op            memory operation code
//   req_addr          byte address
//   req_wdata         store data, value in the low bits
//   resp_valid        one-cycle response pulse
//   resp_rdata        extended load data; 0 for stores and misaligned ops
//   resp_misalign     request was misaligned; no memory access was made
//   dmem_en/we        memory enable and per-lane byte write strobes
//   dmem_addr         word address
//   dmem_wdata        lane-replicated store data
//   dmem_rdata        read word, valid MEM_LATENCY cycles after issue
//   dbg_state         current FSM state (0 IDLE, 1 WAIT, 2 DONE)
// ---------------------------------------------------------------------------
module lsu_dmem_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misalign,
    output logic                  dmem_en,
    output logic [3:0]            dmem_we,
    output logic [ADDR_WIDTH-3:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [1:0]            dbg_state
);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LW  = 3'd2;
    localparam logic [2:0] OP_LBU = 3'd3;
    localparam logic [2:0] OP_LHU = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    // Two bits cover the whole legal latency range of 1..4.
    localparam logic [1:0] LAT_M1 = 2'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [2:0]  op_q;
    logic [1:0]  lane_q;
    logic        misalign;
    logic        is_store;
    logic        accept;
    logic        issue;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    assign req_ready  = (state == ST_IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign issue      = accept && !misalign;
    assign resp_valid = (state == ST_DONE);
    assign dbg_state  = state;
    assign is_store   = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);

    always_comb begin
        misalign = 1'b0;
        case (req_op)
            OP_LH, OP_LHU, OP_SH: misalign = req_addr[0];
            OP_LW, OP_SW:         misalign = |req_addr[1:0];
            default:              misalign = 1'b0;
        endcase
    end

    // Memory issue path. Strobes are forced to zero unless an aligned store
    // is being accepted; address and data are don't-care otherwise.
    assign dmem_en   = issue;
    assign dmem_addr = req_addr[ADDR_WIDTH-1:2];

    always_comb begin
        dmem_we    = 4'b0000;
        dmem_wdata = req_wdata;
        case (req_op)
            OP_SB: begin
                dmem_we    = 4'b0001 << req_addr[1:0];
                dmem_wdata = {4{req_wdata[7:0]}};
            end
            OP_SH: begin
                dmem_we    = req_addr[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{req_wdata[15:0]}};
            end
            OP_SW: begin
                dmem_we    = 4'b1111;
                dmem_wdata = req_wdata;
            end
            default: ;
        endcase
        if (!issue) dmem_we = 4'b0000;
    end

    // Load extension uses the op and byte offset captured at accept time.
    always_comb begin
        byte_sel = dmem_rdata[7:0];
        case (lane_q)
            2'd0: byte_sel = dmem_rdata[7:0];
            2'd1: byte_sel = dmem_rdata[15:8];
            2'd2: byte_sel = dmem_rdata[23:16];
            2'd3: byte_sel = dmem_rdata[31:24];
            default: ;
        endcase
        half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (op_q)
            OP_LB:   load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            OP_LH:   load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            OP_LHU:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = (issue && !is_store) ? ST_WAIT : ST_DONE;
            ST_WAIT: if (cnt == 2'd0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= 2'd0;
            op_q          <= 3'd0;
            lane_q        <= 2'd0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q          <= req_op;
                        lane_q        <= req_addr[1:0];
                        resp_rdata    <= '0;
                        resp_misalign <= misalign;
                        if (issue && !is_store) cnt <= LAT_M1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == 2'd0) resp_rdata <= load_ext;
                    else             cnt        <= cnt - 2'd1;
                end
                ST_DONE: begin
                    // Response fields are only meaningful during the pulse.
                    resp_rdata    <= '0;
                    resp_misalign <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_ctrl
//   Directed bench for lsu_dmem_ctrl. Instance u_dut (latency 1) is backed by
//   a small byte-strobed memory model; instance u_dut3 (latency 3) reads a
//   constant word and is used for latency/ready timing.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_ctrl;

  localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd3;
  localparam logic [2:0] LHU = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

  logic        req_ready, resp_valid, resp_misalign, dmem_en;
  logic [31:0] resp_rdata, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;
  logic [29:0] dmem_addr;
  logic [1:0]  dbg_state;

  logic        req_ready3, resp_valid3, resp_misalign3, dmem_en3;
  logic [31:0] resp_rdata3, dmem_wdata3;
  logic [31:0] dmem_rdata3 = 32'h1357_2468;
  logic [3:0]  dmem_we3;
  logic [29:0] dmem_addr3;
  logic [1:0]  dbg_state3;

  lsu_dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
    .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dbg_state(dbg_state)
  );

  lsu_dmem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_rdata(resp_rdata3), .resp_misalign(resp_misalign3),
    .dmem_en(dmem_en3), .dmem_we(dmem_we3), .dmem_addr(dmem_addr3),
    .dmem_wdata(dmem_wdata3), .dmem_rdata(dmem_rdata3), .dbg_state(dbg_state3)
  );

  // ---------------- memory model (1-cycle read) ----------------
  logic [31:0] mem [0:255];
  logic [31:0] rd_q = 32'd0;
  assign dmem_rdata = rd_q;

  always @(posedge clk) begin
    if (dmem_en) begin
      rd_q <= mem[dmem_addr[7:0]];
      for (int i = 0; i < 4; i++)
        if (dmem_we[i]) mem[dmem_addr[7:0]][8*i +: 8] <= dmem_wdata[8*i +: 8];
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  logic        o_en, o_mis;
  logic [3:0]  o_we;
  logic [29:0] o_wa;
  logic [31:0] o_wd, o_rd;
  int          o_lat;

  // Presents one request to u_dut, captures the issue-cycle memory signals,
  // waits (bounded) for the response and checks that it clears afterwards.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    #1;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    o_en = dmem_en; o_we = dmem_we; o_wa = dmem_addr; o_wd = dmem_wdata;
    @(negedge clk);
    req_valid = 1'b0;
    o_lat = 1;
    while (!resp_valid && o_lat < 16) begin
      @(negedge clk);
      o_lat++;
    end
    o_rd = resp_rdata; o_mis = resp_misalign;
    @(negedge clk);
    chk({tag, ".clr"}, {resp_valid, resp_misalign, 30'd0} | resp_rdata, 32'd0);
  endtask

  task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_mis, input int exp_lat);
    run_op(tag, op, addr, wd);
    chk({tag, ".rdata"}, o_rd, exp_rd);
    chk({tag, ".mis"}, 32'(o_mis), 32'(exp_mis));
    chk({tag, ".lat"}, 32'(o_lat), 32'(exp_lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int seen;
    // Reset state: ready and memory enables held low even with a valid request.
    req_valid = 1'b1; req_op = SW; req_addr = 32'h100;
    repeat (2) @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.en", 32'(dmem_en), 32'd0);
    chk("rst.we", 32'(dmem_we), 32'd0);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.state", 32'(dbg_state), 32'd0);
    chk("rst.ready1", 32'(req_ready), 32'd1);

    // SW then read back.
    check_op("sw100", SW, 32'h100, 32'hDEAD_BEEF, 32'd0, 1'b0, 1);
    chk("sw100.en", 32'(o_en), 32'd1);
    chk("sw100.we", 32'(o_we), 32'hF);
    chk("sw100.addr", 32'(o_wa), 32'h40);
    chk("sw100.wdata", o_wd, 32'hDEAD_BEEF);
    check_op("lw100", LW, 32'h100, 32'd0, 32'hDEAD_BEEF, 1'b0, 2);
    chk("lw100.we", 32'(o_we), 32'd0);

    // Byte store to lane 3 and byte loads back.
    check_op("sb103", SB, 32'h103, 32'h0000_00A5, 32'd0, 1'b0, 1);
    chk("sb103.we", 32'(o_we), 32'h8);
    chk("sb103.wdata", o_wd, 32'hA5A5_A5A5);
    check_op("lb103", LB, 32'h103, 32'd0, 32'hFFFF_FFA5, 1'b0, 2);
    check_op("lbu103", LBU, 32'h103, 32'd0, 32'h0000_00A5, 1'b0, 2);

    // Upper half store.
    check_op("sh102", SH, 32'h102, 32'h0000_1234, 32'd0, 1'b0, 1);
    chk("sh102.we", 32'(o_we), 32'hC);
    chk("sh102.wdata", o_wd, 32'h1234_1234);
    check_op("lw100b", LW, 32'h100, 32'd0, 32'h1234_BEEF, 1'b0, 2);

    // Extension patterns on word 0x80017FFF.
    check_op("sw140", SW, 32'h140, 32'h8001_7FFF, 32'd0, 1'b0, 1);
    check_op("lh142", LH, 32'h142, 32'd0, 32'hFFFF_8001, 1'b0, 2);
    check_op("lhu140", LHU, 32'h140, 32'd0, 32'h0000_7FFF, 1'b0, 2);
    check_op("lw140", LW, 32'h140, 32'd0, 32'h8001_7FFF, 1'b0, 2);
    check_op("lb141", LB, 32'h141, 32'd0, 32'h0000_007F, 1'b0, 2);
    check_op("lbu142", LBU, 32'h142, 32'd0, 32'h0000_0001, 1'b0, 2);
    check_op("lb143", LB, 32'h143, 32'd0, 32'hFFFF_FF80, 1'b0, 2);
    check_op("lh140", LH, 32'h140, 32'd0, 32'h0000_7FFF, 1'b0, 2);

    // Misaligned ops: no access, flagged response, memory untouched.
    check_op("lw102", LW, 32'h102, 32'd0, 32'd0, 1'b1, 1);
    chk("lw102.en", 32'(o_en), 32'd0);
    check_op("sh101", SH, 32'h101, 32'h0000_FFFF, 32'd0, 1'b1, 1);
    chk("sh101.en", 32'(o_en), 32'd0);
    chk("sh101.we", 32'(o_we), 32'd0);
    check_op("lhu143", LHU, 32'h143, 32'd0, 32'd0, 1'b1, 1);
    check_op("sw106", SW, 32'h106, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
    check_op("lw100c", LW, 32'h100, 32'd0, 32'h1234_BEEF, 1'b0, 2);

    // Latency 3 instance: response at T+4, ready back at T+5.
    @(negedge clk);
    req_op = LW; req_addr = 32'h200; req_valid3 = 1'b1;
    #1;
    chk("lat3.en", 32'(dmem_en3), 32'd1);
    chk("lat3.addr", 32'(dmem_addr3), 32'h80);
    @(negedge clk);
    req_valid3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("lat3.ready%0d", k), 32'(req_ready3), 32'(k == 5));
      chk($sformatf("lat3.valid%0d", k), 32'(resp_valid3), 32'(k == 4));
      if (k == 4) chk("lat3.rdata", resp_rdata3, 32'h1357_2468);
      @(negedge clk);
    end

    // Reset while waiting on a read: transaction dropped.
    req_op = LW; req_addr = 32'h100; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid.wait", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.state", 32'(dbg_state), 32'd0);
    chk("rstmid.valid", 32'(resp_valid), 32'd0);
    chk("rstmid.ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    chk("rstmid.noresp", 32'(seen), 32'd0);
    check_op("sw180", SW, 32'h180, 32'h1122_3344, 32'd0, 1'b0, 1);
    check_op("lw180", LW, 32'h180, 32'd0, 32'h1122_3344, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
